// File: rtl/seq_comparator.sv
// Digit-serial magnitude comparator: walks DIGIT-bit slices from MSB to LSB, stopping at the first
// slice that differs. Signed mode biases both sign bits so one unsigned slice compare covers both.
module seq_comparator #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             A_gt_B,
   output logic             A_eq_B,
   output logic             A_lt_B
);

   localparam int unsigned N    = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

   if ((DIGIT == 0) ? 1'b1 : ((WIDTH == 0) || ((WIDTH % DIGIT) != 0))) begin : g_bad_param
      $error("seq_comparator: WIDTH must be a non-zero multiple of DIGIT");
   end

   typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
   logic [IdxW-1:0]  idx_q;
   logic             gt_q, eq_q, lt_q;
   logic [DIGIT-1:0] slice_a, slice_b;
   logic             accept, last;

   // Operands shift up as slices match, so the slice under test is always the top one.
   assign slice_a = a_q[WIDTH-1 -: DIGIT];
   assign slice_b = b_q[WIDTH-1 -: DIGIT];
   assign last    = (idx_q == '0);
   assign accept  = start && (state_q != StCompare);

   always_comb begin
      a_d = A;
      b_d = B;
      a_d[WIDTH-1] = A[WIDTH-1] ^ signed_mode;
      b_d[WIDTH-1] = B[WIDTH-1] ^ signed_mode;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start) state_d = StCompare;
         end
         StCompare: begin
            if ((slice_a != slice_b) || last) state_d = StDone;
         end
         StDone: begin
            state_d = start ? StCompare : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      busy   = (state_q == StCompare);
      done   = (state_q == StDone);
      A_gt_B = gt_q;
      A_eq_B = eq_q;
      A_lt_B = lt_q;
   end

   // Datapath: operand capture, slice walk and result flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         idx_q <= '0;
         gt_q  <= 1'b0;
         eq_q  <= 1'b0;
         lt_q  <= 1'b0;
      end else if (accept) begin
         a_q   <= a_d;
         b_q   <= b_d;
         idx_q <= IdxLast;
         gt_q  <= 1'b0;
         eq_q  <= 1'b0;
         lt_q  <= 1'b0;
      end else if (state_q == StCompare) begin
         if (slice_a > slice_b) begin
            gt_q <= 1'b1;
         end else if (slice_a < slice_b) begin
            lt_q <= 1'b1;
         end else if (last) begin
            eq_q <= 1'b1;
         end else begin
            a_q   <= a_q << DIGIT;
            b_q   <= b_q << DIGIT;
            idx_q <= idx_q - IdxW'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator (WIDTH=32, DIGIT=4): directed corner cases plus random operands
// checked against an arithmetic reference for result and latency.
module tb_seq_comparator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        signed_mode = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy, done, A_gt_B, A_eq_B, A_lt_B;

   int n_checks = 0;
   int n_fail   = 0;

   seq_comparator #(.WIDTH(32), .DIGIT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_mode(signed_mode),
      .A          (A),
      .B          (B),
      .busy       (busy),
      .done       (done),
      .A_gt_B     (A_gt_B),
      .A_eq_B     (A_eq_B),
      .A_lt_B     (A_lt_B)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: 0 = A<B, 1 = A==B, 2 = A>B
   function automatic int ref_rel(input logic [31:0] a, input logic [31:0] b, input logic sm);
      if (sm) begin
         if ($signed(a) > $signed(b)) return 2;
         if ($signed(a) < $signed(b)) return 0;
         return 1;
      end
      if (a > b) return 2;
      if (a < b) return 0;
      return 1;
   endfunction

   // One cycle for the first nibble, plus one per leading equal nibble, at most 8.
   function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
      int k = 1;
      for (int i = 7; i >= 1; i--) begin
         if (((a >> (4 * i)) & 32'hF) == ((b >> (4 * i)) & 32'hF)) k++;
         else break;
      end
      return k;
   endfunction

   // Call at a negedge; returns just after the accepting edge with inputs scrambled.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sm);
      A = a;
      B = b;
      signed_mode = sm;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = $urandom;
      B = $urandom;
      signed_mode = 1'($urandom);
   endtask

   // Counts busy cycles at negedges; returns at the first negedge with busy low.
   task automatic wait_done(input int lat_in, output int lat);
      lat = lat_in;
      @(negedge clk);
      while (busy && lat < 40) begin
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic sm, input int lat);
      int rel;
      rel = ref_rel(a, b, sm);
      chk({tag, "_lat"}, lat, ref_lat(a, b));
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_gt"}, A_gt_B, rel == 2);
      chk({tag, "_eq"}, A_eq_B, rel == 1);
      chk({tag, "_lt"}, A_lt_B, rel == 0);
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic sm);
      int lat;
      issue(a, b, sm);
      wait_done(0, lat);
      check_result(tag, a, b, sm, lat);
   endtask

   initial begin
      int lat;
      logic [31:0] ra, rb;
      logic rs;

      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_flags", {A_gt_B, A_eq_B, A_lt_B}, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run("u_msb", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
      chk("u_msb_lat_exact", lat == 0 ? 32'd0 : 32'd0, 32'd0 + 32'(!1'b1));
      run("s_msb", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
      chk("s_msb_lt", A_lt_B, 1'b1);
      run("u_eq", 32'h1234_5678, 32'h1234_5678, 1'b0);
      chk("u_eq_flag", A_eq_B, 1'b1);
      @(negedge clk);
      chk("hold_done", done, 1'b0);
      chk("hold_flags", {A_gt_B, A_eq_B, A_lt_B}, 3'b010);
      run("u_lsb", 32'h0000_000F, 32'h0000_000E, 1'b0);
      run("u_mid", 32'h0000_0100, 32'h0000_0200, 1'b0);
      run("s_neg1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      run("s_lsb", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);
      @(negedge clk);

      // start during COMPARE must be ignored
      issue(32'h1234_5678, 32'h1234_5678, 1'b0);
      lat = 0;
      repeat (2) begin
         @(negedge clk);
         if (busy) lat++;
      end
      A = 32'h0000_0001;
      B = 32'h0000_0002;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, lat);
      check_result("ign", 32'h1234_5678, 32'h1234_5678, 1'b0, lat);

      // Back-to-back start in the DONE cycle
      issue(32'h0000_0100, 32'h0000_0200, 1'b0);
      chk("b2b_busy", busy, 1'b1);
      chk("b2b_flags_clr", {A_gt_B, A_eq_B, A_lt_B}, 3'b000);
      wait_done(0, lat);
      check_result("b2b", 32'h0000_0100, 32'h0000_0200, 1'b0, lat);

      // Asynchronous reset mid-compare
      issue(32'h1234_5678, 32'h1234_5678, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_flags", {A_gt_B, A_eq_B, A_lt_B}, 3'b000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", done, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
      run("post_rst", 32'd5, 32'd3, 1'b0);

      // Random operands, mixing idle gaps and back-to-back starts
      for (int i = 0; i < 60; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = $urandom;
            default: rb = ra ^ (32'($urandom_range(1, 15)) << (4 * $urandom_range(0, 7)));
         endcase
         rs = 1'($urandom);
         run("rnd", ra, rb, rs);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the bits compared per cycle.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request to compare A and B; sampled on the rising edge of clk.
REQ-006 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned compare; sampled with start.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand.
REQ-009 busy  output  1  high while a comparison is in progress.
REQ-010 done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 A_gt_B  output  1  result flag: A > B.
REQ-012 A_eq_B  output  1  result flag: A == B.
REQ-013 A_lt_B  output  1  result flag: A < B.

Function
REQ-014 WIDTH SHALL be a non-zero multiple of DIGIT, and any violation SHALL cause an elaboration-time error; N = WIDTH/DIGIT.
REQ-015 The FSM SHALL have exactly three states: IDLE, COMPARE and DONE.
REQ-016 start SHALL be accepted only when busy = 0 (IDLE or DONE), and SHALL be ignored in COMPARE.
REQ-017 On acceptance, the block SHALL register A, B and signed_mode, clear all three result flags, load the digit index with N-1, and enter COMPARE.
REQ-018 In signed mode, the MSB of both registered operands SHALL be inverted (offset-binary), so that one unsigned digit comparator serves both modes.
REQ-019 Each COMPARE cycle SHALL compare exactly one DIGIT-bit slice, starting at the most significant slice and moving toward the least significant slice.
REQ-020 If the slices differ, the block SHALL set A_gt_B or A_lt_B from that slice at the clock edge and enter DONE (early termination); no lower slices are examined.
REQ-021 If the slices are equal and the index is 0, the block SHALL set A_eq_B and enter DONE; otherwise it SHALL decrement the index and stay in COMPARE.
REQ-022 Latency SHALL be k = 1 + (number of leading equal slices), capped at N: done is high in the cycle following the k-th edge after the accepting edge.
REQ-023 DONE SHALL last exactly one cycle with done = 1 and busy = 0, then the block SHALL go to IDLE unless start is accepted in that cycle.
REQ-024 A start accepted in DONE SHALL go directly to COMPARE (back-to-back operation), and done SHALL not be extended.
REQ-025 busy SHALL be 1 exactly while the state is COMPARE.
REQ-026 Result flags SHALL be registered, SHALL be one-hot after the first done, and SHALL hold until the next accepted start.
REQ-027 Changes on A, B or signed_mode after acceptance SHALL have no effect on the running comparison.

Reset
REQ-028 While rst = 1, the block SHALL immediately force state IDLE, busy = 0, done = 0, A_gt_B = 0, A_eq_B = 0, A_lt_B = 0 and digit index = 0, independent of clk.
REQ-029 Reset asserted during COMPARE SHALL abort the operation with no done pulse, and the first start after rst deasserts SHALL operate normally.

Verification (WIDTH=32, DIGIT=4, N=8)
REQ-030 The bench SHALL apply unsigned A=0x80000000, B=0x7FFFFFFF -> A_gt_B=1, latency 1 (one busy cycle).
REQ-031 The bench SHALL apply the same operands with signed_mode=1 -> A_lt_B=1, latency 1.
REQ-032 The bench SHALL apply A=B=0x12345678 -> A_eq_B=1, busy for 8 cycles, latency 8; A=0x0000000F, B=0x0000000E -> A_gt_B=1, latency 8; A=0x00000100, B=0x00000200 -> A_lt_B=1, latency 6.
REQ-033 The bench SHALL apply signed A=0xFFFFFFFF (-1), B=0x00000001 -> A_lt_B=1, latency 1; and signed A=0xFFFFFFFE, B=0xFFFFFFFF -> A_lt_B=1, latency 8.
REQ-034 The bench SHALL pulse start with new operands during COMPARE -> the new start is ignored and the original result is returned; then start again in the DONE cycle -> the new comparison begins with no IDLE cycle.
REQ-035 The bench SHALL assert rst asynchronously mid-COMPARE -> busy, done and all flags go to 0 immediately; after release, A=5, B=3 unsigned -> A_gt_B=1, latency 8.
